mode_selector_n: RTL and testbench

- Parametrised mode selector for the clock front panel: cycles through NUM_MODES user modes (1..NUM_MODES) with up/down buttons, and wraps at both ends.
- Parks the output at IDLE (0) while disabled, saves the last active mode, and resumes it on re-enable.
- Adds edge-detected stepping, hold-to-auto-repeat, up+down conflict rejection and a mode-change pulse.
- Sits between the debounced button block and the display/setting datapath.

---
 rtl/mode_selector_n_pkg.sv | 30 +++
 rtl/mode_selector_n_btn_repeat.sv | 50 +++++
 rtl/mode_selector_n.sv | 101 ++++++++++
 tb/tb_mode_selector_n.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mode_selector_n_pkg.sv
// Shared types and wrap helpers for the front-panel mode selector.
// Mode 0 is IDLE; active modes are 1..num_modes and wrap at both ends.
package mode_sel_pkg;

    typedef enum logic {
        ST_SUSPEND = 1'b0,
        ST_ACTIVE  = 1'b1
    } state_t;

    localparam int MODE_IDLE = 0;

    // Any out-of-range mode maps to 1 so a corrupted value recovers on the next step.
    function automatic int mode_inc(input int m, input int num_modes);
        if (m < 1 || m >= num_modes) begin
            return 1;
        end
        return m + 1;
    endfunction

    function automatic int mode_dec(input int m, input int num_modes);
        if (m == 1) begin
            return num_modes;
        end
        if (m < 1 || m > num_modes) begin
            return 1;
        end
        return m - 1;
    endfunction

endpackage

// File: rtl/mode_selector_n_btn_repeat.sv
// Per-button step generator: rising-edge press detection plus hold-to-auto-repeat.
// A step is suppressed, and the hold run restarts, whenever the other button is also down.
module btn_repeat #(
    parameter int RPT_DELAY  = 50,
    parameter int RPT_PERIOD = 10,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic other_btn,
    output logic step
);

    logic             r_btnQ;
    logic             r_rep;
    logic [CNT_W-1:0] r_cnt;

    logic             w_hold;
    logic [CNT_W-1:0] w_cntNext;
    logic [CNT_W-1:0] w_target;
    logic             w_tick;

    assign w_hold    = btn & ~other_btn;
    assign w_cntNext = r_cnt + CNT_W'(1);
    assign w_target  = r_rep ? CNT_W'(RPT_PERIOD) : CNT_W'(RPT_DELAY);
    assign w_tick    = w_hold & (w_cntNext == w_target);
    assign step      = w_hold & ((btn & ~r_btnQ) | w_tick);

    // r_cnt holds the number of earlier held cycles, so the press cycle counts as 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btnQ <= 1'b0;
            r_cnt  <= '0;
            r_rep  <= 1'b0;
        end else begin
            r_btnQ <= btn;
            if (!w_hold) begin
                r_cnt <= '0;
                r_rep <= 1'b0;
            end else if (w_tick) begin
                r_cnt <= '0;
                r_rep <= 1'b1;
            end else begin
                r_cnt <= w_cntNext;
            end
        end
    end

endmodule

// File: rtl/mode_selector_n.sv
// Front-panel mode selector: steps through 1..NUM_MODES with up/down buttons,
// parks at IDLE while disabled and resumes the saved mode on re-enable.
module mode_selector_n
    import mode_sel_pkg::*;
#(
    parameter int NUM_MODES    = 4,
    parameter int MODE_W       = 3,
    parameter int DEFAULT_MODE = 1,
    parameter int RPT_DELAY    = 50,
    parameter int RPT_PERIOD   = 10,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up,
    input  logic              down,
    output logic [MODE_W-1:0] mode,
    output logic              mode_valid,
    output logic              mode_chg
);

    state_t            r_state;
    logic [MODE_W-1:0] r_mode;
    logic [MODE_W-1:0] r_saved;
    logic              r_modeValid;
    logic              r_modeChg;

    logic              w_stepUp;
    logic              w_stepDn;

    btn_repeat #(
        .RPT_DELAY  (RPT_DELAY),
        .RPT_PERIOD (RPT_PERIOD),
        .CNT_W      (CNT_W)
    ) u_rptUp (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (up),
        .other_btn (down),
        .step      (w_stepUp)
    );

    btn_repeat #(
        .RPT_DELAY  (RPT_DELAY),
        .RPT_PERIOD (RPT_PERIOD),
        .CNT_W      (CNT_W)
    ) u_rptDn (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (down),
        .other_btn (up),
        .step      (w_stepDn)
    );

    // Disable wins over any step; mode_chg marks every edge that alters the mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SUSPEND;
            r_mode      <= MODE_W'(MODE_IDLE);
            r_saved     <= MODE_W'(DEFAULT_MODE);
            r_modeValid <= 1'b0;
            r_modeChg   <= 1'b0;
        end else begin
            r_modeChg <= 1'b0;
            case (r_state)
                ST_SUSPEND: begin
                    if (en) begin
                        r_state     <= ST_ACTIVE;
                        r_mode      <= r_saved;
                        r_modeValid <= 1'b1;
                        r_modeChg   <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (!en) begin
                        r_state     <= ST_SUSPEND;
                        r_saved     <= r_mode;
                        r_mode      <= MODE_W'(MODE_IDLE);
                        r_modeValid <= 1'b0;
                        r_modeChg   <= 1'b1;
                    end else if (w_stepUp) begin
                        r_mode    <= MODE_W'(mode_inc(int'(r_mode), NUM_MODES));
                        r_modeChg <= 1'b1;
                    end else if (w_stepDn) begin
                        r_mode    <= MODE_W'(mode_dec(int'(r_mode), NUM_MODES));
                        r_modeChg <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_SUSPEND;
                end
            endcase
        end
    end

    assign mode       = r_mode;
    assign mode_valid = r_modeValid;
    assign mode_chg   = r_modeChg;

endmodule

// File: tb/tb_mode_selector_n.sv
// Bench for mode_selector_n: a run-length based behavioural model checked every cycle,
// plus directed scenarios with hand-computed mode values.
module tb_mode_selector_n;

    localparam int NUM_MODES  = 4;
    localparam int RPT_DELAY  = 50;
    localparam int RPT_PERIOD = 10;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       down;
    logic [2:0] mode;
    logic       mode_valid;
    logic       mode_chg;

    int total = 0;
    int bad   = 0;
    bit started = 0;

    // Model state: plain integers describing the user-visible behaviour.
    int mActive = 0;
    int mMode   = 0;
    int mSaved  = 1;
    int mChg    = 0;
    int mValid  = 0;
    int prevUp  = 0;
    int prevDn  = 0;
    int runUp   = 0;
    int runDn   = 0;

    mode_selector_n #(
        .NUM_MODES    (NUM_MODES),
        .MODE_W       (3),
        .DEFAULT_MODE (1),
        .RPT_DELAY    (RPT_DELAY),
        .RPT_PERIOD   (RPT_PERIOD),
        .CNT_W        (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .up         (up),
        .down       (down),
        .mode       (mode),
        .mode_valid (mode_valid),
        .mode_chg   (mode_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int isRepeat(input int run);
        if (run == RPT_DELAY) return 1;
        if (run > RPT_DELAY && ((run - RPT_DELAY) % RPT_PERIOD) == 0) return 1;
        return 0;
    endfunction

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0d, want %0d", name, $time, got, want);
        end
    endtask

    // Run lengths of "held alone" cycles drive auto-repeat; presses are level rises.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mActive = 0; mMode = 0; mSaved = 1; mChg = 0; mValid = 0;
            prevUp = 0; prevDn = 0; runUp = 0; runDn = 0;
        end else begin
            int stepUp, stepDn;
            runUp = (up && !down) ? runUp + 1 : 0;
            runDn = (down && !up) ? runDn + 1 : 0;
            stepUp = (up && !down && ((up && !prevUp) || isRepeat(runUp))) ? 1 : 0;
            stepDn = (down && !up && ((down && !prevDn) || isRepeat(runDn))) ? 1 : 0;
            prevUp = int'(up);
            prevDn = int'(down);
            mChg = 0;
            if (!mActive) begin
                if (en) begin
                    mActive = 1; mMode = mSaved; mValid = 1; mChg = 1;
                end
            end else if (!en) begin
                mSaved = mMode; mMode = 0; mActive = 0; mValid = 0; mChg = 1;
            end else if (stepUp) begin
                mMode = (mMode == NUM_MODES) ? 1 : mMode + 1;
                mChg = 1;
            end else if (stepDn) begin
                mMode = (mMode == 1) ? NUM_MODES : mMode - 1;
                mChg = 1;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (started) begin
            check("cyc_mode", int'(mode), mMode);
            check("cyc_valid", int'(mode_valid), mValid);
            check("cyc_chg", int'(mode_chg), mChg);
        end
    end

    task automatic applyStimulus(input bit e, input bit u, input bit d, input int n);
        @(negedge clk);
        en = e; up = u; down = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int expMode, input int expValid, input int expChg);
        check({name, "_mode"}, int'(mode), expMode);
        check({name, "_valid"}, int'(mode_valid), expValid);
        check({name, "_chg"}, int'(mode_chg), expChg);
        check({name, "_model"}, mMode, expMode);
    endtask

    initial begin
        en = 0; up = 0; down = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        started = 1;
        #1;
        checkOutput("reset", 0, 0, 0);

        applyStimulus(1, 0, 0, 1);
        checkOutput("enable", 1, 1, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("enable_settle", 1, 1, 0);

        begin
            int expSeq[4] = '{2, 3, 4, 1};
            for (int i = 0; i < 4; i++) begin
                applyStimulus(1, 1, 0, 1);
                checkOutput($sformatf("up_step%0d", i), expSeq[i], 1, 1);
                applyStimulus(1, 0, 0, 1);
                checkOutput($sformatf("up_rel%0d", i), expSeq[i], 1, 0);
            end
        end

        applyStimulus(1, 0, 1, 1);
        checkOutput("down_wrap", 4, 1, 1);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 1, 1);
        checkOutput("down_again", 3, 1, 1);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 1, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("down_to2", 2, 1, 0);

        applyStimulus(1, 1, 0, 49);
        checkOutput("hold_49", 3, 1, 0);
        applyStimulus(1, 1, 0, 1);
        checkOutput("hold_50", 4, 1, 1);
        applyStimulus(1, 1, 0, 10);
        checkOutput("hold_60", 1, 1, 1);
        applyStimulus(1, 1, 0, 11);
        checkOutput("hold_71", 2, 1, 0);
        applyStimulus(1, 0, 0, 5);
        checkOutput("hold_release", 2, 1, 0);

        applyStimulus(1, 1, 0, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("pre_conflict", 3, 1, 0);
        applyStimulus(1, 1, 1, 100);
        checkOutput("conflict", 3, 1, 0);
        applyStimulus(1, 1, 0, 49);
        checkOutput("post_conflict49", 3, 1, 0);
        applyStimulus(1, 1, 0, 1);
        checkOutput("post_conflict50", 4, 1, 1);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 1, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("back_to3", 3, 1, 0);

        applyStimulus(0, 0, 0, 1);
        checkOutput("disable", 0, 0, 1);
        applyStimulus(0, 1, 0, 1);
        checkOutput("disabled_up", 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 1, 0, 2);
        applyStimulus(1, 1, 0, 1);
        checkOutput("resume_held", 3, 1, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("resume_settle", 3, 1, 0);

        applyStimulus(1, 1, 0, 40);
        checkOutput("hold_40", 4, 1, 0);
        @(negedge clk);
        rst_n = 1'b0;
        en = 0; up = 0;
        #1;
        checkOutput("async_reset", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 1);
        checkOutput("post_reset", 0, 0, 0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("post_reset_en", 1, 1, 1);
        applyStimulus(1, 0, 0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
